// File: rtl/clock_pkg.sv
// Shared types and field arithmetic for the manual time-setting controller.
package clock_pkg;

    typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, COMMIT} state_t;
    typedef enum logic [1:0] {F_HR, F_MIN, F_SEC} field_t;

    localparam int HR_W = 5;
    localparam int MS_W = 6;
    localparam logic [HR_W-1:0] HOURS_MAX  = 5'd23;
    localparam logic [MS_W-1:0] MINSEC_MAX = 6'd59;

    function automatic field_t field_of(input state_t s);
        case (s)
            SET_MIN: return F_MIN;
            SET_SEC: return F_SEC;
            default: return F_HR;
        endcase
    endfunction

    function automatic state_t next_field_state(input state_t s);
        case (s)
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_SEC;
            default: return SET_HR;
        endcase
    endfunction

    // inc and dec together cancel out
    function automatic logic [HR_W-1:0] step_hr(input logic [HR_W-1:0] v, input logic up, input logic dn);
        if (up == dn) return v;
        if (up) return (v == HOURS_MAX) ? '0 : v + HR_W'(1);
        return (v == '0) ? HOURS_MAX : v - HR_W'(1);
    endfunction

    function automatic logic [MS_W-1:0] step_ms(input logic [MS_W-1:0] v, input logic up, input logic dn);
        if (up == dn) return v;
        if (up) return (v == MINSEC_MAX) ? '0 : v + MS_W'(1);
        return (v == '0) ? MINSEC_MAX : v - MS_W'(1);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// 2-FF synchronizer, stability debounce and edge pulses for one raw input.
// Auto-repeat of held presses exists only when CLKSET_AUTO_REPEAT_EN is defined.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000,
    parameter bit          REPEAT_EN        = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic press,
    output logic fall
);

`ifdef CLKSET_AUTO_REPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif

    logic        sync1, sync2;
    logic        db, db_q;
    logic [31:0] db_cnt;
    logic [31:0] rpt_cnt;
    logic        rise, rpt_fire;

    // NOTE: every register here uses <= so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db;
            if (sync2 != db) begin
                if (db_cnt == DEBOUNCE_CYC - 1) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 32'd1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    // rpt_cnt holds the number of cycles since the press; reloads keep later repeats on the rate grid
    assign rpt_fire = AUTO_RPT && REPEAT_EN && db && db_q && (rpt_cnt == REPEAT_DELAY_CYC);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt <= '0;
        end else if (rise) begin
            rpt_cnt <= 32'd1;
        end else if (rpt_fire) begin
            rpt_cnt <= REPEAT_DELAY_CYC - REPEAT_RATE_CYC + 1;
        end else if (db) begin
            rpt_cnt <= rpt_cnt + 32'd1;
        end
    end

    assign press = rise | rpt_fire;

endmodule

// File: rtl/clock_set_controller.sv
// Manual time-set sequencer: edits a shadow copy of the time and commits it with a load pulse.
// Optional auto-repeat on inc/dec: define CLKSET_AUTO_REPEAT_EN.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 1_000_000,
    parameter int unsigned TIMEOUT_CYC      = 1_500_000_000,
    parameter int unsigned BLINK_HALF_CYC   = 12_500_000,
    parameter int unsigned REPEAT_DELAY_CYC = 25_000_000,
    parameter int unsigned REPEAT_RATE_CYC  = 5_000_000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sw_set,
    input  logic            btn_mode,
    input  logic            btn_inc,
    input  logic            btn_dec,
    input  logic [HR_W-1:0] cur_hours,
    input  logic [MS_W-1:0] cur_minutes,
    input  logic [MS_W-1:0] cur_seconds,
    output logic            run_en,
    output logic            load,
    output logic [HR_W-1:0] load_hours,
    output logic [MS_W-1:0] load_minutes,
    output logic [MS_W-1:0] load_seconds,
    output logic [2:0]      blink_mask,
    output logic            set_active
);

    state_t          state, state_nx;
    field_t          field;
    logic [HR_W-1:0] sh_hr, sh_hr_nx;
    logic [MS_W-1:0] sh_min, sh_min_nx, sh_sec, sh_sec_nx;
    logic [31:0]     idle_cnt, blink_cnt;
    logic            blink_on;
    logic            mode_p, inc_p, dec_p, set_req, set_done;
    logic [2:0]      btn_fall_unused;
    logic            in_set, any_press, timeout;

    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
                         .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b0))
        u_mode (.clk(clk), .reset_n(reset_n), .raw(btn_mode), .press(mode_p), .fall(btn_fall_unused[0]));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
                         .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1))
        u_inc (.clk(clk), .reset_n(reset_n), .raw(btn_inc), .press(inc_p), .fall(btn_fall_unused[1]));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
                         .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b1))
        u_dec (.clk(clk), .reset_n(reset_n), .raw(btn_dec), .press(dec_p), .fall(btn_fall_unused[2]));
    button_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_DELAY_CYC(REPEAT_DELAY_CYC),
                         .REPEAT_RATE_CYC(REPEAT_RATE_CYC), .REPEAT_EN(1'b0))
        u_set (.clk(clk), .reset_n(reset_n), .raw(sw_set), .press(set_req), .fall(set_done));

    assign in_set    = state inside {SET_HR, SET_MIN, SET_SEC};
    assign field     = field_of(state);
    assign any_press = mode_p | inc_p | dec_p;
    assign timeout   = in_set && !any_press && (idle_cnt == TIMEOUT_CYC - 1);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        sh_hr_nx  = sh_hr;
        sh_min_nx = sh_min;
        sh_sec_nx = sh_sec;
        case (state)
            RUN: begin
                if (set_req) begin
                    state_nx  = SET_HR;
                    sh_hr_nx  = cur_hours;
                    sh_min_nx = cur_minutes;
                    sh_sec_nx = cur_seconds;
                end
            end
            SET_HR, SET_MIN, SET_SEC: begin
                // arithmetic uses the field selected before any mode advance
                case (field)
                    F_HR:    sh_hr_nx  = step_hr(sh_hr, inc_p, dec_p);
                    F_MIN:   sh_min_nx = step_ms(sh_min, inc_p, dec_p);
                    default: sh_sec_nx = step_ms(sh_sec, inc_p, dec_p);
                endcase
                if (set_done)     state_nx = COMMIT;
                else if (mode_p)  state_nx = next_field_state(state);
                else if (timeout) state_nx = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // NOTE: the shadow is reset as well, so load_* never show X before the first SET entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= RUN;
            sh_hr  <= '0;
            sh_min <= '0;
            sh_sec <= '0;
        end else begin
            state  <= state_nx;
            sh_hr  <= sh_hr_nx;
            sh_min <= sh_min_nx;
            sh_sec <= sh_sec_nx;
        end
    end

    // blink phase restarts on every state change, i.e. SET entry and each field advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b0;
        end else begin
            idle_cnt <= (in_set && !any_press) ? idle_cnt + 32'd1 : '0;
            if (!in_set || state_nx != state) begin
                blink_cnt <= '0;
                blink_on  <= 1'b0;
            end else if (blink_cnt == BLINK_HALF_CYC - 1) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        blink_mask = 3'b000;
        if (in_set && blink_on) begin
            case (field)
                F_HR:    blink_mask = 3'b100;
                F_MIN:   blink_mask = 3'b010;
                default: blink_mask = 3'b001;
            endcase
        end
    end

    assign run_en       = (state == RUN);
    assign load         = (state == COMMIT);
    assign set_active   = in_set;
    assign load_hours   = sh_hr;
    assign load_minutes = sh_min;
    assign load_seconds = sh_sec;

endmodule

// File: tb/tb_clock_set_controller.sv
// Bench for clock_set_controller: cycle model of the set-time rules plus directed literal checks.
module tb_clock_set_controller;

    localparam int DEB   = 4;
    localparam int TMO   = 200;
    localparam int BLK   = 8;
    localparam int RDLY  = 20;
    localparam int RRATE = 5;
`ifdef CLKSET_AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, sw_set, btn_mode, btn_inc, btn_dec;
    logic [4:0] cur_hours;
    logic [5:0] cur_minutes, cur_seconds;
    logic       run_en, load, set_active;
    logic [4:0] load_hours;
    logic [5:0] load_minutes, load_seconds;
    logic [2:0] blink_mask;

    clock_set_controller #(
        .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO), .BLINK_HALF_CYC(BLK),
        .REPEAT_DELAY_CYC(RDLY), .REPEAT_RATE_CYC(RRATE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sw_set(sw_set), .btn_mode(btn_mode),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .cur_hours(cur_hours),
        .cur_minutes(cur_minutes), .cur_seconds(cur_seconds), .run_en(run_en),
        .load(load), .load_hours(load_hours), .load_minutes(load_minutes),
        .load_seconds(load_seconds), .blink_mask(blink_mask), .set_active(set_active)
    );

    always #10 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // index: 0=mode 1=inc 2=dec 3=sw_set
    int       n;
    bit [3:0] s1m, s2m, dbm, ev_rise, ev_fall;
    int       run_len[4];
    int       since[4];
    bit       m_in_set, m_commit;
    int       m_field, m_h, m_m, m_s, m_fstart, m_last;
    bit       e_run, e_set, e_load;
    logic [2:0] e_mask;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n = 0; s1m = '0; s2m = '0; dbm = '0; ev_rise = '0; ev_fall = '0;
            for (int i = 0; i < 4; i++) begin run_len[i] = 0; since[i] = 0; end
            m_in_set = 1'b0; m_commit = 1'b0; m_field = 0;
            m_h = 0; m_m = 0; m_s = 0; m_fstart = 0; m_last = 0;
        end else begin
            bit pm, pinc, pdec, pr, pf, seen_b, flip;
            bit [3:0] raw;
            int delta;
            n++;
            pm = ev_rise[0]; pinc = ev_rise[1]; pdec = ev_rise[2]; pr = ev_rise[3]; pf = ev_fall[3];
            if (m_commit) begin
                m_commit = 1'b0;
            end else if (!m_in_set) begin
                if (pr) begin
                    m_in_set = 1'b1; m_field = 0;
                    m_h = int'(cur_hours); m_m = int'(cur_minutes); m_s = int'(cur_seconds);
                    m_fstart = n; m_last = n;
                end
            end else begin
                delta = int'(pinc) - int'(pdec);
                case (m_field)
                    0: m_h = (m_h + delta + 24) % 24;
                    1: m_m = (m_m + delta + 60) % 60;
                    default: m_s = (m_s + delta + 60) % 60;
                endcase
                if (pf) begin
                    m_in_set = 1'b0; m_commit = 1'b1;
                end else if (pm) begin
                    m_field = (m_field + 1) % 3; m_fstart = n;
                end else if (!(pinc || pdec) && (n - m_last) >= TMO) begin
                    m_in_set = 1'b0;
                end
                if (pm || pinc || pdec) m_last = n;
            end
            // input conditioning: press events seen by the next edge
            raw = {sw_set, btn_dec, btn_inc, btn_mode};
            for (int i = 0; i < 4; i++) begin
                seen_b = s2m[i]; s2m[i] = s1m[i]; s1m[i] = raw[i];
                ev_rise[i] = 1'b0; ev_fall[i] = 1'b0; flip = 1'b0;
                if (seen_b != dbm[i]) begin
                    run_len[i]++;
                    if (run_len[i] == DEB) begin
                        dbm[i] = seen_b; run_len[i] = 0; flip = 1'b1; since[i] = 0;
                        if (seen_b) ev_rise[i] = 1'b1; else ev_fall[i] = 1'b1;
                    end
                end else begin
                    run_len[i] = 0;
                end
                if (!flip && dbm[i]) begin
                    since[i]++;
                    if (AUTO && (i == 1 || i == 2) && since[i] >= RDLY && (since[i] - RDLY) % RRATE == 0)
                        ev_rise[i] = 1'b1;
                end
            end
        end
        e_run  = !m_in_set && !m_commit;
        e_set  = m_in_set;
        e_load = m_commit;
        e_mask = (m_in_set && ((n - m_fstart) / BLK) % 2 == 1) ? (3'b100 >> m_field) : 3'b000;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("run_en", int'(run_en), int'(e_run));
            check("set_active", int'(set_active), int'(e_set));
            check("load", int'(load), int'(e_load));
            check("blink_mask", int'(blink_mask), int'(e_mask));
            if (e_load) begin
                check("load_hours", int'(load_hours), m_h);
                check("load_minutes", int'(load_minutes), m_m);
                check("load_seconds", int'(load_seconds), m_s);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int         loads;
    logic [4:0] lh;
    logic [5:0] lm, ls;
    logic [2:0] seen;

    task automatic run(input int k);
        for (int j = 0; j < k; j++) begin
            @(negedge clk);
            if (load === 1'b1) begin
                loads++; lh = load_hours; lm = load_minutes; ls = load_seconds;
            end
            seen = seen | blink_mask;
        end
    endtask

    task automatic press_btns(input bit m, input bit i, input bit d, input int hold);
        btn_mode = m; btn_inc = i; btn_dec = d;
        run(hold);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        run(10);
    endtask

    task automatic enter(input int h, input int m, input int s);
        cur_hours = 5'(h); cur_minutes = 6'(m); cur_seconds = 6'(s);
        loads = 0;
        sw_set = 1'b1;
        run(12);
    endtask

    task automatic check_load(input string tag, input int h, input int m, input int s);
        check({tag, "_load_count"}, loads, 1);
        check({tag, "_load_hours"}, int'(lh), h);
        check({tag, "_load_minutes"}, int'(lm), m);
        check({tag, "_load_seconds"}, int'(ls), s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int       dur[4];
        bit [3:0] lvl;
        reset_n = 1'b0; sw_set = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        cur_hours = '0; cur_minutes = '0; cur_seconds = '0;
        loads = 0; seen = '0; lh = '0; lm = '0; ls = '0;
        #35;
        check("rst_run_en", int'(run_en), 1);
        check("rst_load", int'(load), 0);
        check("rst_blink_mask", int'(blink_mask), 0);
        check("rst_set_active", int'(set_active), 0);
        check("rst_load_hours", int'(load_hours), 0);
        check("rst_load_minutes", int'(load_minutes), 0);
        check("rst_load_seconds", int'(load_seconds), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // idle in RUN
        run(100);
        check("idle_loads", loads, 0);
        check("idle_run_en", int'(run_en), 1);
        check("idle_set_active", int'(set_active), 0);

        // 23:59:58, one inc on hours wraps to 0
        enter(23, 59, 58);
        check("entry_set_active", int'(set_active), 1);
        check("entry_run_en", int'(run_en), 0);
        press_btns(0, 1, 0, 8);
        sw_set = 1'b0;
        run(12);
        check_load("wrap_hr", 0, 59, 58);
        check("after_commit_run_en", int'(run_en), 1);

        // field walk, blink bits, seconds dec wrap
        enter(12, 34, 0);
        press_btns(1, 0, 0, 8);
        press_btns(1, 0, 0, 8);
        seen = '0;
        run(20);
        check("sec_blink_seen", int'(seen), 3'b001);
        press_btns(0, 0, 1, 8);
        press_btns(1, 0, 0, 8);
        seen = '0;
        run(20);
        check("hr_blink_seen", int'(seen), 3'b100);
        sw_set = 1'b0;
        run(12);
        check_load("sec_dec_wrap", 12, 34, 59);

        // same-cycle combinations, commit together with a press
        enter(10, 30, 5);
        press_btns(1, 0, 0, 8);
        press_btns(0, 1, 1, 8);
        press_btns(1, 1, 0, 8);
        btn_inc = 1'b1; sw_set = 1'b0;
        run(8);
        btn_inc = 1'b0;
        run(12);
        check_load("same_cycle", 10, 31, 6);

        // timeout abort, sw_set held high stays in RUN
        enter(1, 2, 3);
        run(230);
        check("timeout_set_active", int'(set_active), 0);
        check("timeout_run_en", int'(run_en), 1);
        check("timeout_loads", loads, 0);
        run(50);
        check("timeout_stays_run", int'(set_active), 0);
        sw_set = 1'b0;
        run(12);

        // long hold and bounce on inc
        enter(5, 10, 20);
        press_btns(0, 1, 0, RDLY + 3 * RRATE);
        btn_inc = 1'b1; run(3); btn_inc = 1'b0; run(3);
        btn_inc = 1'b1; run(3); btn_inc = 1'b0; run(12);
        sw_set = 1'b0;
        run(12);
        check_load("hold_inc", AUTO ? 9 : 6, 10, 20);

        // randomized phase, checked by the model every cycle
        lvl = '0;
        for (int i = 0; i < 4; i++) dur[i] = int'($urandom_range(20, 1));
        for (int c = 0; c < 5000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (dur[i] == 0) begin
                    lvl[i] = ~lvl[i];
                    if (i == 3)       dur[i] = int'($urandom_range(500, 20));
                    else if (lvl[i])  dur[i] = int'($urandom_range(14, 1));
                    else              dur[i] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(300, 100))
                                                                           : int'($urandom_range(14, 1));
                end
                dur[i]--;
            end
            {sw_set, btn_dec, btn_inc, btn_mode} = lvl;
            cur_hours   = 5'($urandom_range(23, 0));
            cur_minutes = 6'($urandom_range(59, 0));
            cur_seconds = 6'($urandom_range(59, 0));
            run(1);
        end
        {sw_set, btn_dec, btn_inc, btn_mode} = 4'b0000;
        run(40);
        check("final_run_en", int'(run_en), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
